// File: rtl/sys_feeder.sv
// Activation feeder: accepts one vector per cycle and re-emits it as a diagonal
// wavefront (row r delayed r cycles). Optional macro: FEEDER_ZERO_GATE_EN.
module sys_feeder #(
    parameter int unsigned ROWS       = 16,
    parameter int unsigned A_BITWIDTH = 8,
    parameter int unsigned LEN_W      = 10
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [LEN_W-1:0]                     tile_len,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [ROWS-1:0][A_BITWIDTH-1:0]      in_data,
    output logic [ROWS-1:0]                      if_en,
    output logic [ROWS-1:0][A_BITWIDTH-1:0]      if_data,
    output logic                                 busy,
    output logic                                 done
);

    localparam int unsigned DRAIN_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } state_t;

    state_t               state;
    logic [LEN_W-1:0]     len_q;
    logic [LEN_W-1:0]     cnt_q;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic                 xfer_c;
    logic                 last_xfer_c;

    assign xfer_c      = in_valid && in_ready;
    assign last_xfer_c = xfer_c && (cnt_q == (len_q - LEN_W'(1)));

    // Tile framing: accept count, drain timer, registered handshake and status
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            drain_cnt <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        if (tile_len != '0) begin
                            state    <= STREAM;
                            len_q    <= tile_len;
                            cnt_q    <= '0;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (xfer_c) begin
                        cnt_q <= cnt_q + LEN_W'(1);
                        if (last_xfer_c) begin
                            in_ready  <= 1'b0;
                            state     <= DRAIN;
                            drain_cnt <= '0;
                        end
                    end
                end
                DRAIN: begin
                    // done lands in the IDLE cycle so a start there is honoured
                    if (drain_cnt == DRAIN_W'(ROWS - 1)) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DRAIN_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Per-lane skew chain: lane r has r+1 stages, enable travels with the data
    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        logic [r:0]                  en_pipe;
        logic [r:0][A_BITWIDTH-1:0]  d_pipe;
        logic [r:0]                  en_nxt;
        logic [r:0][A_BITWIDTH-1:0]  d_raw;
        logic [r:0][A_BITWIDTH-1:0]  d_nxt;
        logic [A_BITWIDTH-1:0]       d_head;

        assign d_head = in_ready ? in_data[r] : '0;

        if (r == 0) begin : g_head
            assign en_nxt = xfer_c;
            assign d_raw  = d_head;
        end else begin : g_tail
            assign en_nxt = {en_pipe[r-1:0], xfer_c};
            assign d_raw  = {d_pipe[r-1:0], d_head};
        end

`ifdef FEEDER_ZERO_GATE_EN
        // Gate at the last register's input so the output stays registered
        always_comb begin
            d_nxt = d_raw;
            if (!en_nxt[r]) begin
                d_nxt[r] = '0;
            end
        end
`else
        assign d_nxt = d_raw;
`endif

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                en_pipe <= '0;
                d_pipe  <= '0;
            end else begin
                en_pipe <= en_nxt;
                d_pipe  <= d_nxt;
            end
        end

        assign if_en[r]   = en_pipe[r];
        assign if_data[r] = d_pipe[r];
    end

endmodule

// File: tb/tb_sys_feeder.sv
// Self-checking bench for sys_feeder (ROWS=4): per-cycle model compare plus
// hand-computed literal checks. Honours FEEDER_ZERO_GATE_EN like the design.
module tb_sys_feeder;

    localparam int unsigned ROWS = 4;
    localparam int unsigned AW   = 8;
    localparam int unsigned LW   = 10;
    localparam int          MAXC = 4096;

    logic                     clk;
    logic                     rst;
    logic                     start;
    logic [LW-1:0]            tile_len;
    logic                     in_valid;
    logic                     in_ready;
    logic [ROWS-1:0][AW-1:0]  in_data;
    logic [ROWS-1:0]          if_en;
    logic [ROWS-1:0][AW-1:0]  if_data;
    logic                     busy;
    logic                     done;

    sys_feeder #(.ROWS(ROWS), .A_BITWIDTH(AW), .LEN_W(LW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .tile_len (tile_len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .if_en    (if_en),
        .if_data  (if_data),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, exp);
        end
    endtask

    // Behavioural model: accepted-vector history plus tile bookkeeping
    int                       cyc       = 0;
    int                       rst_wm    = 0;
    int                       finish_at = -1;
    int                       m_len     = 0;
    int                       m_cnt     = 0;
    bit                       m_active  = 1'b0;
    bit                       e_ready   = 1'b0;
    bit                       e_busy    = 1'b0;
    bit                       e_done    = 1'b0;
    bit                       en_h  [MAXC];
    logic [ROWS-1:0][AW-1:0]  dat_h [MAXC];
    bit                       cmp_on = 1'b0;

    always @(posedge clk) begin : model
        bit xfer;
        bit n_done;
        if (!rst) begin
            rst_wm    = cyc;
            m_active  = 1'b0;
            finish_at = -1;
            e_ready   = 1'b0;
            e_busy    = 1'b0;
            e_done    = 1'b0;
            en_h[cyc]  = 1'b0;
            dat_h[cyc] = '0;
        end else begin
            xfer       = in_valid && e_ready;
            en_h[cyc]  = xfer;
            dat_h[cyc] = e_ready ? in_data : '0;
            if (e_done) m_active = 1'b0;
            if (xfer) begin
                m_cnt++;
                if (m_cnt == m_len) finish_at = cyc + int'(ROWS) + 1;
            end
            n_done = (finish_at == cyc + 1);
            if (start && !m_active) begin
                if (tile_len != '0) begin
                    m_active = 1'b1;
                    m_len    = int'(tile_len);
                    m_cnt    = 0;
                end else begin
                    n_done = 1'b1;
                end
            end
            e_done  = n_done;
            e_busy  = m_active;
            e_ready = m_active && (m_cnt < m_len);
        end
        cyc++;
    end

    // Compare every cycle: row r reflects the transfer made r+1 cycles earlier
    always @(negedge clk) begin : compare
        logic [ROWS-1:0]          x_en;
        logic [ROWS-1:0][AW-1:0]  x_d;
        int k;
        if (cmp_on) begin
            for (int r = 0; r < int'(ROWS); r++) begin
                k = cyc - 1 - r;
                if (rst && k >= 0 && k > rst_wm) begin
                    x_en[r] = en_h[k];
                    x_d[r]  = dat_h[k][r];
`ifdef FEEDER_ZERO_GATE_EN
                    if (!x_en[r]) x_d[r] = '0;
`endif
                end else begin
                    x_en[r] = 1'b0;
                    x_d[r]  = '0;
                end
            end
            chk("in_ready", 64'(in_ready), 64'(rst ? e_ready : 1'b0));
            chk("busy",     64'(busy),     64'(rst ? e_busy  : 1'b0));
            chk("done",     64'(done),     64'(rst ? e_done  : 1'b0));
            chk("if_en",    64'(if_en),    64'(x_en));
            chk("if_data",  64'(if_data),  64'(x_d));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit s, input int len, input bit v, input logic [ROWS-1:0][AW-1:0] d);
        start    = s;
        tile_len = LW'(len);
        in_valid = v;
        in_data  = d;
    endtask

    function automatic logic [ROWS-1:0][AW-1:0] vec(input int i);
        logic [ROWS-1:0][AW-1:0] v;
        for (int r = 0; r < int'(ROWS); r++) v[r] = AW'(4 * i + r + 1);
        return v;
    endfunction

    function automatic logic [ROWS-1:0][AW-1:0] fill(input logic [AW-1:0] b);
        logic [ROWS-1:0][AW-1:0] v;
        for (int r = 0; r < int'(ROWS); r++) v[r] = b;
        return v;
    endfunction

    // Three-vector tile started at local cycle 0, optional one-cycle bubble
    task automatic run_tile(input bit gap);
        logic [AW-1:0] bub;
`ifdef FEEDER_ZERO_GATE_EN
        bub = 8'h00;
`else
        bub = 8'hAA;
`endif
        for (int k = 0; k <= 11; k++) begin
            if (!gap) begin
                if (k == 2) begin chk("t1_r0_c2_en", 64'(if_en[0]), 64'd1); chk("t1_r0_c2", 64'(if_data[0]), 64'd1); end
                if (k == 4) chk("t1_r0_c4", 64'(if_data[0]), 64'd9);
                if (k == 5) chk("t1_r3_c5", 64'(if_data[3]), 64'd4);
                if (k == 7) begin chk("t1_r3_c7", 64'(if_data[3]), 64'd12); chk("t1_done_c7", 64'(done), 64'd0); end
                if (k == 8) begin chk("t1_done_c8", 64'(done), 64'd1); chk("t1_busy_c8", 64'(busy), 64'd1); end
                if (k == 9) chk("t1_busy_c9", 64'(busy), 64'd0);
            end else begin
                if (k == 3) begin chk("t2_r0_gap_en", 64'(if_en[0]), 64'd0); chk("t2_r0_gap_data", 64'(if_data[0]), 64'(bub)); end
                if (k == 4) chk("t2_r0_c4", 64'(if_data[0]), 64'd5);
                if (k == 6) chk("t2_r3_gap_en", 64'(if_en[3]), 64'd0);
                if (k == 8) chk("t2_done_c8", 64'(done), 64'd0);
                if (k == 9) chk("t2_done_c9", 64'(done), 64'd1);
            end
            if (k == 0)                 drive(1'b1, 3, 1'b0, '0);
            else if (!gap && k <= 3)    drive(1'b0, 0, 1'b1, vec(k - 1));
            else if (gap && k == 1)     drive(1'b0, 0, 1'b1, vec(0));
            else if (gap && k == 2)     drive(1'b0, 0, 1'b0, fill(8'hAA));
            else if (gap && k <= 4)     drive(1'b0, 0, 1'b1, vec(k - 2));
            else                        drive(1'b0, 0, 1'b0, '0);
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        drive(1'b0, 0, 1'b0, '0);
        tick();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_if_en",    64'(if_en),    64'd0);
        chk("rst_if_data",  64'(if_data),  64'd0);
        chk("rst_busy",     64'(busy),     64'd0);
        chk("rst_done",     64'(done),     64'd0);
        cmp_on = 1'b1;
        tick();
        rst = 1'b1;
        tick();

        run_tile(1'b0);
        run_tile(1'b1);

        // Zero-length tile
        for (int k = 0; k <= 3; k++) begin
            if (k == 1) begin chk("z_done", 64'(done), 64'd1); chk("z_busy", 64'(busy), 64'd0); chk("z_ready", 64'(in_ready), 64'd0); end
            if (k == 2) chk("z_done_once", 64'(done), 64'd0);
            if (k == 0) drive(1'b1, 0, 1'b1, vec(3)); else drive(1'b0, 0, 1'b0, '0);
            tick();
        end

        // Starts during STREAM and DRAIN are ignored
        for (int k = 0; k <= 9; k++) begin
            if (k == 3) chk("ign_ready_drain", 64'(in_ready), 64'd0);
            if (k == 6) chk("ign_done_c6", 64'(done), 64'd0);
            if (k == 7) chk("ign_done_c7", 64'(done), 64'd1);
            if (k == 8) begin chk("ign_busy_c8", 64'(busy), 64'd0); chk("ign_done_c8", 64'(done), 64'd0); end
            case (k)
                0:       drive(1'b1, 2, 1'b0, '0);
                1:       drive(1'b1, 5, 1'b1, vec(0));
                2:       drive(1'b0, 0, 1'b1, vec(1));
                3:       drive(1'b1, 7, 1'b1, vec(2));
                default: drive(1'b0, 0, 1'b0, '0);
            endcase
            tick();
        end

        // Back-to-back: start in the done cycle
        for (int k = 0; k <= 15; k++) begin
            if (k == 6) chk("b2b_done", 64'(done), 64'd1);
            if (k == 7) begin chk("b2b_busy", 64'(busy), 64'd1); chk("b2b_ready", 64'(in_ready), 64'd1); end
            if (k == 13) chk("b2b_done2", 64'(done), 64'd1);
            case (k)
                0:       drive(1'b1, 1, 1'b0, '0);
                1:       drive(1'b0, 0, 1'b1, vec(5));
                6:       drive(1'b1, 2, 1'b0, '0);
                7, 8:    drive(1'b0, 0, 1'b1, vec(k));
                default: drive(1'b0, 0, 1'b0, '0);
            endcase
            tick();
        end

        // Reset mid-tile at the cycle row 1 first asserts
        for (int k = 0; k <= 3; k++) begin
            if (k == 3) begin
                chk("mid_r1_en", 64'(if_en[1]), 64'd1);
                rst = 1'b0;
                #1;
                chk("mid_rst_en",   64'(if_en),   64'd0);
                chk("mid_rst_data", 64'(if_data), 64'd0);
                chk("mid_rst_busy", 64'(busy),    64'd0);
                drive(1'b0, 0, 1'b0, '0);
            end else if (k == 0) begin
                drive(1'b1, 3, 1'b0, '0);
            end else begin
                drive(1'b0, 0, 1'b1, vec(k - 1));
            end
            tick();
        end
        tick();
        rst = 1'b1;
        tick();
        run_tile(1'b0);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sys_feeder.md
# sys_feeder

Activation feeder that drives the input-feature side of the systolic array. It accepts one full activation vector per cycle from the activation buffer through a valid/ready handshake and re-emits it as a diagonal wavefront: row r is presented r cycles after row 0. This produces the staggered `if_en`/`if_data` pattern the array's rows require. It sits between the activation buffer and the array's `if_en`/`if_data` inputs, and it frames each tile with `busy`/`done` for the controller.

## Interface
Parameters:
- ROWS, 16, number of array rows; equals SUPER_SYS_ROWS.
- A_BITWIDTH, 8, activation width per lane.
- LEN_W, 10, width of the tile-length field.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle tile start; honoured only in IDLE.
- tile_len  in  LEN_W  number of vectors in the tile; sampled on an accepted start.
- in_valid  in  1  `in_data` holds a valid vector.
- in_ready  out  1  feeder accepts a vector this cycle.
- in_data  in  [ROWS-1:0][A_BITWIDTH-1:0]  activation vector; lane r is destined for row r.
- if_en  out  [ROWS-1:0]  per-row valid, skewed; goes to the array.
- if_data  out  [ROWS-1:0][A_BITWIDTH-1:0]  per-row activation, skewed; goes to the array.
- busy  out  1  high from the accepted start until done, inclusive.
- done  out  1  one-cycle pulse when the tile's last wavefront has fully left row ROWS-1.

## Operation
- FSM states: IDLE, STREAM, DRAIN.
- IDLE → STREAM on start when tile_len ≠ 0. This latches tile_len and clears the accept counter.
- IDLE with start and tile_len = 0: no state change; `done` pulses the next cycle; `busy` stays 0.
- STREAM:
  - in_ready = (accept count < latched tile_len).
  - A transfer is in_valid && in_ready; each transfer increments the count.
  - STREAM → DRAIN in the cycle after the transfer that makes count = tile_len.
- Skew: lane r passes through a chain of r+1 registers, so every lane has at least one output register. The enable travels alongside the data.
- When in_valid is low in STREAM, a zero enable enters every lane. The resulting bubble propagates diagonally: row r shows if_en[r]=0 r cycles later. Bubbles are never compacted.
- DRAIN:
  - A counter runs ROWS cycles.
  - On expiry: `done`=1 for one cycle and the FSM returns to IDLE.
  - in_ready=0 throughout DRAIN.
- start while busy is ignored, with no effect on the latched length.
- in_data is not sampled when in_ready=0; in_valid high outside STREAM is ignored.
- No arithmetic on data: values pass bit-exact. The counter saturates at tile_len and never wraps.

## Timing
- Reset values: in_ready=0, if_en=0, if_data=0, busy=0, done=0, FSM=IDLE. All skew registers are cleared asynchronously.
- Latency: a transfer in cycle t appears at row r with if_en[r]=1 in cycle t+1+r.
- start accepted in cycle s: busy=1 and in_ready=1 (if tile_len>0) from cycle s+1.
- Final transfer in cycle t:
  - DRAIN occupies t+1 … t+ROWS.
  - The last if_en[ROWS-1]=1 occurs in t+ROWS.
  - done=1 and busy=1 in t+ROWS+1; FSM=IDLE and busy=0 from t+ROWS+2.
- A new start is accepted in or after the done cycle. A start in the done cycle is accepted; the next tile's first row-0 output cannot overlap the previous tile.
- Reset asserted mid-tile: all outputs drop to reset values immediately. In-flight wavefronts are discarded; no done pulse is issued.

## Configuration
- FEEDER_ZERO_GATE_EN defined: each if_data[r] is forced to 0 whenever if_en[r]=0, including bubbles and DRAIN tails. This keeps array multipliers quiet.
- Not defined: if_data lanes expose raw skew-register contents regardless of if_en. The output AND gates are removed. Consumers must qualify data with if_en.

## Test plan
- ROWS=4, tile_len=3, in_valid held 1, vectors {1,2,3,4},{5,6,7,8},{9,10,11,12}, start at cycle 0:
  - Row 0 shows 1,5,9 in cycles 2–4.
  - Row 3 shows 4,8,12 in cycles 5–7.
  - done in cycle 8.
- Same tile with in_valid low for one cycle between vector 1 and vector 2: every row shows one if_en=0 gap at its skewed slot; done is delayed one cycle (cycle 9).
- start with tile_len=0: done pulses once, busy never rises, if_en stays 0, in_ready stays 0.
- start pulses in STREAM and DRAIN: ignored; exactly one done; the latched length is unchanged.
- rst low at the cycle row 1 first asserts: all if_en and if_data become 0 at once; no done pulse; a fresh start after release runs normally.
- FEEDER_ZERO_GATE_EN on vs off with a bubble of data 0xAA presented with in_valid=0: gated build shows if_data=0; ungated build shows 0xAA with if_en=0.
